// File: rtl/fadd_pipe.sv
// Three-stage IEEE-754-style adder/subtractor with valid/ready handshake.
// Round to nearest even, subnormals kept, and a whole-pipe stall on output backpressure.
module fadd_pipe #(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int SUB_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] res,
  output logic                 ovf,
  output logic                 nv
);
  localparam int FW = 1 + EXP_W + MAN_W;
  localparam int AW = MAN_W + 4;   // hidden bit, fraction, guard, round, sticky
  localparam int SW = AW + 1;      // plus carry out of the add
  localparam int LW = $clog2(SW + 1);
  localparam int IW = EXP_W + 2;

  function automatic logic [AW-1:0] align_sticky(input logic [AW-1:0] x,
                                                 input logic [EXP_W-1:0] sh);
    logic [AW-1:0] lost_mask;
    if (int'(sh) >= AW - 1) return {{(AW-1){1'b0}}, |x};
    lost_mask = ~({AW{1'b1}} << sh);
    return (x >> sh) | {{(AW-1){1'b0}}, |(x & lost_mask)};
  endfunction

  function automatic logic [LW-1:0] lzc(input logic [SW-1:0] x);
    logic [LW-1:0] n;
    logic          done;
    n    = '0;
    done = 1'b0;
    for (int i = SW - 1; i >= 0; i--) begin
      if (!done && !x[i]) n = n + 1'b1;
      else done = 1'b1;
    end
    return n;
  endfunction

  function automatic logic rne_up(input logic lsb, input logic g,
                                  input logic r, input logic s);
    return g & (lsb | r | s);
  endfunction

  logic stall, adv;
  logic out_valid_q, ovf_q, nv_q;
  logic [FW-1:0] res_q;

  assign stall     = out_valid_q & ~out_ready;
  assign adv       = ~stall;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign ovf       = ovf_q;
  assign nv        = nv_q;

  // S1: classify, order by magnitude, align the smaller operand
  logic             sub_eff, sa, sb, swap, inf_a, inf_b, nan_a, nan_b;
  logic [EXP_W-1:0] ea, eb, eea, eeb;
  logic [MAN_W-1:0] fa, fb;
  logic [MAN_W:0]   ma, mb;

  assign sub_eff = (SUB_EN != 0) & sub;
  assign sa      = a[FW-1];
  assign sb      = b[FW-1] ^ sub_eff;
  assign ea      = a[FW-2:MAN_W];
  assign eb      = b[FW-2:MAN_W];
  assign fa      = a[MAN_W-1:0];
  assign fb      = b[MAN_W-1:0];
  assign inf_a   = (&ea) & ~(|fa);
  assign inf_b   = (&eb) & ~(|fb);
  assign nan_a   = (&ea) & (|fa);
  assign nan_b   = (&eb) & (|fb);
  assign eea     = (ea == '0) ? EXP_W'(1) : ea;
  assign eeb     = (eb == '0) ? EXP_W'(1) : eb;
  assign ma      = {|ea, fa};
  assign mb      = {|eb, fb};
  assign swap    = b[FW-2:0] > a[FW-2:0];

  logic             sign_p0_d, esub_p0_d, nan_p0_d, inf_p0_d, infs_p0_d;
  logic [EXP_W-1:0] exp_p0_d;
  logic [AW-1:0]    man_l_p0_d, man_s_p0_d;

  always_comb begin
    sign_p0_d  = swap ? sb : sa;
    esub_p0_d  = sa ^ sb;
    exp_p0_d   = swap ? eeb : eea;
    man_l_p0_d = swap ? {mb, 3'b000} : {ma, 3'b000};
    man_s_p0_d = align_sticky(swap ? {ma, 3'b000} : {mb, 3'b000},
                              swap ? (eeb - eea) : (eea - eeb));
    nan_p0_d   = nan_a | nan_b | (inf_a & inf_b & (sa ^ sb));
    inf_p0_d   = inf_a | inf_b;
    infs_p0_d  = inf_a ? sa : sb;
  end

  logic             vld_p0_q, sign_p0_q, esub_p0_q, nan_p0_q, inf_p0_q, infs_p0_q;
  logic [EXP_W-1:0] exp_p0_q;
  logic [AW-1:0]    man_l_p0_q, man_s_p0_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   vld_p0_q <= 1'b0;
    else if (adv) vld_p0_q <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      sign_p0_q  <= sign_p0_d;
      esub_p0_q  <= esub_p0_d;
      exp_p0_q   <= exp_p0_d;
      man_l_p0_q <= man_l_p0_d;
      man_s_p0_q <= man_s_p0_d;
      nan_p0_q   <= nan_p0_d;
      inf_p0_q   <= inf_p0_d;
      infs_p0_q  <= infs_p0_d;
    end
  end

  // S2: magnitude add/subtract and leading-zero count
  logic [SW-1:0] sum_p1_d;
  logic [LW-1:0] lz_p1_d;

  assign sum_p1_d = esub_p0_q ? ({1'b0, man_l_p0_q} - {1'b0, man_s_p0_q})
                              : ({1'b0, man_l_p0_q} + {1'b0, man_s_p0_q});
  assign lz_p1_d  = lzc(sum_p1_d);

  logic             vld_p1_q, sign_p1_q, esub_p1_q, nan_p1_q, inf_p1_q, infs_p1_q;
  logic [EXP_W-1:0] exp_p1_q;
  logic [SW-1:0]    sum_p1_q;
  logic [LW-1:0]    lz_p1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   vld_p1_q <= 1'b0;
    else if (adv) vld_p1_q <= vld_p0_q;
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      sign_p1_q <= sign_p0_q;
      esub_p1_q <= esub_p0_q;
      exp_p1_q  <= exp_p0_q;
      sum_p1_q  <= sum_p1_d;
      lz_p1_q   <= lz_p1_d;
      nan_p1_q  <= nan_p0_q;
      inf_p1_q  <= inf_p0_q;
      infs_p1_q <= infs_p0_q;
    end
  end

  // S3: normalise (left shift clamped at exponent 1 for subnormals), round, pack
  logic [IW-1:0]    e_l, lz_w, lz_adj, sh, e_n, e_f;
  logic [AW-1:0]    norm;
  logic             up;
  logic [MAN_W+1:0] mant;
  logic [MAN_W-1:0] frac;
  logic [FW-1:0]    res_d;
  logic             ovf_d, nv_d;

  always_comb begin
    e_l    = {2'b00, exp_p1_q};
    lz_w   = IW'(lz_p1_q);
    lz_adj = '0;
    sh     = '0;
    norm   = '0;
    e_n    = '0;
    if (sum_p1_q[SW-1]) begin
      norm = {sum_p1_q[SW-1:2], |sum_p1_q[1:0]};
      e_n  = e_l + IW'(1);
    end else begin
      lz_adj = lz_w - IW'(1);
      sh     = (lz_adj < (e_l - IW'(1))) ? lz_adj : (e_l - IW'(1));
      norm   = sum_p1_q[AW-1:0] << sh;
      e_n    = e_l - sh;
    end
    up   = rne_up(norm[3], norm[2], norm[1], norm[0]);
    mant = {1'b0, norm[AW-1:3]} + {{(MAN_W+1){1'b0}}, up};
    if (mant[MAN_W+1]) begin
      e_f  = e_n + IW'(1);
      frac = mant[MAN_W:1];
    end else begin
      e_f  = mant[MAN_W] ? e_n : '0;
      frac = mant[MAN_W-1:0];
    end

    res_d = {sign_p1_q, e_f[EXP_W-1:0], frac};
    ovf_d = 1'b0;
    nv_d  = 1'b0;
    if (nan_p1_q) begin
      res_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      nv_d  = 1'b1;
    end else if (inf_p1_q) begin
      res_d = {infs_p1_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (sum_p1_q == '0) begin
      res_d = {sign_p1_q & ~esub_p1_q, {(FW-1){1'b0}}};
    end else if (e_f >= IW'({EXP_W{1'b1}})) begin
      res_d = {sign_p1_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      ovf_q       <= 1'b0;
      nv_q        <= 1'b0;
    end else if (adv) begin
      out_valid_q <= vld_p1_q;
      res_q       <= res_d;
      ovf_q       <= ovf_d;
      nv_q        <= nv_d;
    end
  end

endmodule

// File: tb/tb_fadd_pipe.sv
// Directed bench for fadd_pipe (binary32): latency, rounding, specials,
// backpressure ordering and asynchronous reset behaviour.
module tb_fadd_pipe;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, sub, out_valid, out_ready, ovf, nv;
  logic [31:0] a, b, res;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  fadd_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .ovf(ovf), .nv(nv)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic sv, input logic [31:0] r, input logic o, input logic n);
    @(posedge clk); #1;
    a = av; b = bv; sub = sv; in_valid = 1'b1; out_ready = 1'b1;
    chk($sformatf("%s.rdy", tag), in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("%s.early", tag), out_valid, 0);
    @(posedge clk); #1;
    chk($sformatf("%s.vld", tag), out_valid, 1);
    chk($sformatf("%s.res", tag), res, r);
    chk($sformatf("%s.flags", tag), {ovf, nv}, {o, n});
  endtask

  logic [31:0] bpa [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                           32'hC0000000, 32'h00000001, 32'h3F800000};
  logic [31:0] bpb [6] = '{32'h3F800000, 32'h3F800000, 32'h3F800000,
                           32'h3F800000, 32'h00000001, 32'h33C00000};
  logic        bps [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [31:0] bpr [6] = '{32'h40000000, 32'h40400000, 32'h40000000,
                           32'hBF800000, 32'h00000002, 32'h3F800001};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int ai, oi, seen;
    logic stalled_prev;
    logic [31:0] res_prev;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst.vld", out_valid, 0);
    chk("rst.res", res, 0);
    chk("rst.flags", {ovf, nv}, 0);
    chk("rst.rdy", in_ready, 1);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel.rdy", in_ready, 1);

    run_op("one_plus_one", 32'h3F800000, 32'h3F800000, 0, 32'h40000000, 0, 0);
    run_op("tie_even",     32'h3F800000, 32'h33800000, 0, 32'h3F800000, 0, 0);
    run_op("tie_odd",      32'h3F800001, 32'h33800000, 0, 32'h3F800002, 0, 0);
    run_op("sub_min",      32'h00000001, 32'h00000001, 0, 32'h00000002, 0, 0);
    run_op("x_minus_x",    32'h3F800000, 32'h3F800000, 1, 32'h00000000, 0, 0);
    run_op("ovf",          32'h7F7FFFFF, 32'h7F7FFFFF, 0, 32'h7F800000, 1, 0);
    run_op("inf_m_inf",    32'h7F800000, 32'hFF800000, 0, 32'h7FC00000, 0, 1);
    run_op("nan_in",       32'h7FC00001, 32'h3F800000, 0, 32'h7FC00000, 0, 1);
    run_op("inf_fin",      32'h7F800000, 32'h3F800000, 0, 32'h7F800000, 0, 0);
    run_op("ninf_ninf",    32'hFF800000, 32'hFF800000, 0, 32'hFF800000, 0, 0);
    run_op("inf_sub_inf",  32'h7F800000, 32'h7F800000, 1, 32'h7FC00000, 0, 1);
    run_op("neg_zero",     32'h80000000, 32'h80000000, 0, 32'h80000000, 0, 0);
    run_op("nz_sub_pz",    32'h80000000, 32'h00000000, 1, 32'h80000000, 0, 0);
    run_op("opp_cancel",   32'h3F800000, 32'hBF800000, 0, 32'h00000000, 0, 0);
    run_op("three_m_one",  32'h40400000, 32'h3F800000, 1, 32'h40000000, 0, 0);
    run_op("norm_to_sub",  32'h00800000, 32'h00000001, 1, 32'h007FFFFF, 0, 0);
    run_op("sub_to_norm",  32'h007FFFFF, 32'h00000001, 0, 32'h00800000, 0, 0);
    run_op("neg_res",      32'hC0000000, 32'h3F800000, 0, 32'hBF800000, 0, 0);
    run_op("rnd_carry",    32'h3FFFFFFF, 32'h33800000, 0, 32'h40000000, 0, 0);
    run_op("sticky_up",    32'h3F800000, 32'h33C00000, 0, 32'h3F800001, 0, 0);
    run_op("collapse",     32'h3F800000, 32'h00000001, 1, 32'h3F800000, 0, 0);
    run_op("rnd_ovf",      32'h7F7FFFFF, 32'h73000000, 0, 32'h7F800000, 1, 0);

    // Back-to-back stream with the consumer stalling for four cycles
    ai = 0; oi = 0; stalled_prev = 1'b0; res_prev = '0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk); #1;
      if (stalled_prev) begin
        chk("bp.hold_res", res, res_prev);
        chk("bp.hold_vld", out_valid, 1);
      end
      in_valid  = (ai < 6);
      if (ai < 6) begin a = bpa[ai]; b = bpb[ai]; sub = bps[ai]; end
      out_ready = !(cyc >= 5 && cyc < 9);
      #1;
      chk("bp.in_ready", in_ready, !(out_valid && !out_ready));
      if (in_valid && in_ready) ai++;
      if (out_valid && out_ready) begin
        if (oi < 6) chk($sformatf("bp.res%0d", oi), res, bpr[oi]);
        else chk("bp.extra", oi, 5);
        oi++;
      end
      stalled_prev = out_valid && !out_ready;
      res_prev     = res;
    end
    in_valid = 1'b0;
    chk("bp.count", oi, 6);

    // Asynchronous reset with three operations in flight
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      a = bpa[k]; b = bpb[k]; sub = bps[k]; in_valid = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid.pre_vld", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid.vld", out_valid, 0);
    chk("mid.res", res, 0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid.rdy", in_ready, 1);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    chk("mid.ghost", seen, 0);

    run_op("after_rst", 32'h40000000, 32'h3F800000, 0, 32'h40400000, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
